// File: rtl/actuator_column_sequencer.sv
// -----------------------------------------------------------------------------
// actuator_column_sequencer
//
// Drives the H-bridge pads of a NUM_COLS x NUM_ROWS actuator (braille) cell.
// A start request snapshots the target dot state and the CCR timing values,
// then walks the columns. Each column gets a SET phase (column pulled low,
// selected rows pulled high) and a CLEAR phase (column pulled high, selected
// rows pulled low). Each drive phase is followed by dead time. A gap separates
// consecutive columns that actually drive something. Any phase whose mask is
// empty is skipped together with its dead time. The sequence ends with a
// one-cycle active-low done pulse.
//
// Ports
//   clock, reset_n   system clock, asynchronous active-low reset
//   enable           block enable; low aborts a running sequence
//   start            one-cycle request, accepted only when idle and enabled
//   target_state     requested dot state (dot = col*NUM_ROWS + row)
//   use_past         1: drive only dots that differ from past_state
//   invert           1: target_state is inverted before use
//   ccr0..ccr3       dead time, SET width, CLEAR width, inter-column gap
//   row_pn, col_pn   {p,n} pad pairs: 00 drive0, 11 drive1, 10 Hi-Z
//   past_state       last completed (post-invert) target
//   busy             high while a sequence is in flight
//   done_n           active-low one-cycle completion pulse
// -----------------------------------------------------------------------------
module actuator_column_sequencer #(
  parameter int NUM_COLS = 2,
  parameter int NUM_ROWS = 5,
  parameter int TIMER_W  = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           start,
  input  logic [NUM_COLS*NUM_ROWS-1:0]   target_state,
  input  logic                           use_past,
  input  logic                           invert,
  input  logic [TIMER_W-1:0]             ccr0,
  input  logic [TIMER_W-1:0]             ccr1,
  input  logic [TIMER_W-1:0]             ccr2,
  input  logic [TIMER_W-1:0]             ccr3,
  output logic [2*NUM_ROWS-1:0]          row_pn,
  output logic [2*NUM_COLS-1:0]          col_pn,
  output logic [NUM_COLS*NUM_ROWS-1:0]   past_state,
  output logic                           busy,
  output logic                           done_n
);

  localparam int NUM_DOTS = NUM_COLS * NUM_ROWS;
  localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  localparam logic [2*NUM_ROWS-1:0] ROWS_HIZ = {NUM_ROWS{2'b10}};
  localparam logic [2*NUM_COLS-1:0] COLS_HIZ = {NUM_COLS{2'b10}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_DEAD1,
    S_CLEAR,
    S_DEAD2,
    S_GAP,
    S_DONE
  } state_e;

  // Rows of one column taken out of a dot-indexed mask.
  function automatic logic [NUM_ROWS-1:0] col_slice(input logic [NUM_DOTS-1:0] m,
                                                    input int c);
    return m[c*NUM_ROWS +: NUM_ROWS];
  endfunction

  // A zero CCR value still yields a one-cycle phase.
  function automatic logic [TIMER_W-1:0] phase_len(input logic [TIMER_W-1:0] v);
    return (v == '0) ? TIMER_W'(1) : v;
  endfunction

  function automatic logic [2*NUM_ROWS-1:0] row_drive(input logic [NUM_ROWS-1:0] sel,
                                                      input logic [1:0]          lvl);
    logic [2*NUM_ROWS-1:0] pads;
    pads = ROWS_HIZ;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (sel[r]) pads[2*r +: 2] = lvl;
    end
    return pads;
  endfunction

  function automatic logic [2*NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] c,
                                                      input logic [1:0]       lvl);
    logic [2*NUM_COLS-1:0] pads;
    pads = COLS_HIZ;
    pads[2*int'(c) +: 2] = lvl;
    return pads;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q,  state_d;
  logic [COL_W-1:0]        col_q,    col_d;
  logic [TIMER_W-1:0]      cnt_q,    cnt_d;
  logic [NUM_DOTS-1:0]     set_q,    set_d;
  logic [NUM_DOTS-1:0]     clr_q,    clr_d;
  logic [NUM_DOTS-1:0]     t_q,      t_d;
  logic [TIMER_W-1:0]      ccr0_q,   ccr0_d;
  logic [TIMER_W-1:0]      ccr1_q,   ccr1_d;
  logic [TIMER_W-1:0]      ccr2_q,   ccr2_d;
  logic [TIMER_W-1:0]      ccr3_q,   ccr3_d;
  logic [2*NUM_ROWS-1:0]   row_pn_q, row_pn_d;
  logic [2*NUM_COLS-1:0]   col_pn_q, col_pn_d;
  logic [NUM_DOTS-1:0]     past_q,   past_d;
  logic                    busy_q,   busy_d;
  logic                    done_n_q, done_n_d;

  // ---------------------------------------------------------------------------
  // Working values: on the accept cycle the fresh inputs are used, otherwise
  // the snapshot taken at accept time.
  // ---------------------------------------------------------------------------
  logic                  accept;
  logic [NUM_DOTS-1:0]   t_new, set_new, clr_new;
  logic [NUM_DOTS-1:0]   t_use, set_use, clr_use;
  logic [TIMER_W-1:0]    ccr0_use, ccr1_use, ccr2_use, ccr3_use;
  logic [NUM_COLS-1:0]   col_live;
  int                    search_lo;
  logic                  found;
  logic [COL_W-1:0]      found_col;
  logic                  last;
  logic                  adv;
  state_e                tgt;
  logic [COL_W-1:0]      tgt_col;

  assign accept  = (state_q == S_IDLE) && enable && start;
  assign t_new   = invert ? ~target_state : target_state;
  assign set_new = use_past ? (t_new & ~past_q) : t_new;
  assign clr_new = use_past ? (~t_new & past_q) : ~t_new;

  assign t_use    = accept ? t_new   : t_q;
  assign set_use  = accept ? set_new : set_q;
  assign clr_use  = accept ? clr_new : clr_q;
  assign ccr0_use = accept ? ccr0    : ccr0_q;
  assign ccr1_use = accept ? ccr1    : ccr1_q;
  assign ccr2_use = accept ? ccr2    : ccr2_q;
  assign ccr3_use = accept ? ccr3    : ccr3_q;

  assign last = (cnt_q <= TIMER_W'(1));

  // Next column that has at least one phase to run. On accept the search
  // starts at column 0, otherwise just after the current column; empty
  // columns in between are skipped so they consume no cycles.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // before any branch, otherwise paths that skip it infer a latch.
    col_live  = '0;
    found     = 1'b0;
    found_col = '0;
    search_lo = accept ? 0 : int'(col_q) + 1;
    for (int c = 0; c < NUM_COLS; c++) begin
      col_live[c] = (|col_slice(set_use, c)) | (|col_slice(clr_use, c));
      if (!found && (c >= search_lo) && col_live[c]) begin
        found     = 1'b1;
        found_col = COL_W'(c);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    set_d    = set_q;
    clr_d    = clr_q;
    t_d      = t_q;
    ccr0_d   = ccr0_q;
    ccr1_d   = ccr1_q;
    ccr2_d   = ccr2_q;
    ccr3_d   = ccr3_q;
    row_pn_d = row_pn_q;
    col_pn_d = col_pn_q;
    past_d   = past_q;
    busy_d   = busy_q;
    done_n_d = done_n_q;
    adv      = 1'b0;
    tgt      = state_q;
    tgt_col  = col_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          adv = 1'b1;
          if (found) begin
            tgt_col = found_col;
            tgt     = (|col_slice(set_use, int'(found_col))) ? S_SET : S_CLEAR;
          end else begin
            tgt = S_DONE;
          end
        end
      end
      S_SET: begin
        if (last) begin
          adv = 1'b1;
          tgt = S_DEAD1;
        end
      end
      S_DEAD1: begin
        if (last) begin
          adv = 1'b1;
          if (|col_slice(clr_use, int'(col_q))) begin
            tgt = S_CLEAR;
          end else if (found) begin
            tgt     = S_GAP;
            tgt_col = found_col;
          end else begin
            tgt = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        if (last) begin
          adv = 1'b1;
          tgt = S_DEAD2;
        end
      end
      S_DEAD2: begin
        if (last) begin
          adv = 1'b1;
          if (found) begin
            tgt     = S_GAP;
            tgt_col = found_col;
          end else begin
            tgt = S_DONE;
          end
        end
      end
      S_GAP: begin
        if (last) begin
          adv = 1'b1;
          tgt = (|col_slice(set_use, int'(col_q))) ? S_SET : S_CLEAR;
        end
      end
      S_DONE: begin
        adv = 1'b1;
        tgt = S_IDLE;
      end
      default: begin
        adv = 1'b1;
        tgt = S_IDLE;
      end
    endcase

    if (accept) begin
      set_d  = set_new;
      clr_d  = clr_new;
      t_d    = t_new;
      ccr0_d = ccr0;
      ccr1_d = ccr1;
      ccr2_d = ccr2;
      ccr3_d = ccr3;
    end

    if (adv) begin
      state_d  = tgt;
      col_d    = tgt_col;
      busy_d   = (tgt != S_IDLE) && (tgt != S_DONE);
      done_n_d = (tgt != S_DONE);
      if (tgt == S_DONE) past_d = t_use;

      // Counter reloads on every state entry.
      unique case (tgt)
        S_SET:            cnt_d = phase_len(ccr1_use);
        S_CLEAR:          cnt_d = phase_len(ccr2_use);
        S_DEAD1, S_DEAD2: cnt_d = phase_len(ccr0_use);
        S_GAP:            cnt_d = phase_len(ccr3_use);
        default:          cnt_d = TIMER_W'(1);
      endcase

      // Every drive phase is entered from or left to an all-Hi-Z state, so a
      // column and a row never flip polarity on the same edge.
      row_pn_d = ROWS_HIZ;
      col_pn_d = COLS_HIZ;
      if (tgt == S_SET) begin
        row_pn_d = row_drive(col_slice(set_use, int'(tgt_col)), 2'b11);
        col_pn_d = col_drive(tgt_col, 2'b00);
      end else if (tgt == S_CLEAR) begin
        row_pn_d = row_drive(col_slice(clr_use, int'(tgt_col)), 2'b00);
        col_pn_d = col_drive(tgt_col, 2'b11);
      end
    end else begin
      cnt_d = cnt_q - TIMER_W'(1);
    end

    // Disable wins over everything: abort to idle, float the pads, no done
    // pulse and the previous completed state is kept.
    if (!enable) begin
      state_d  = S_IDLE;
      row_pn_d = ROWS_HIZ;
      col_pn_d = COLS_HIZ;
      busy_d   = 1'b0;
      done_n_d = 1'b1;
      past_d   = past_q;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      cnt_q    <= '0;
      set_q    <= '0;
      clr_q    <= '0;
      t_q      <= '0;
      ccr0_q   <= '0;
      ccr1_q   <= '0;
      ccr2_q   <= '0;
      ccr3_q   <= '0;
      row_pn_q <= ROWS_HIZ;
      col_pn_q <= COLS_HIZ;
      past_q   <= '0;
      busy_q   <= 1'b0;
      done_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      set_q    <= set_d;
      clr_q    <= clr_d;
      t_q      <= t_d;
      ccr0_q   <= ccr0_d;
      ccr1_q   <= ccr1_d;
      ccr2_q   <= ccr2_d;
      ccr3_q   <= ccr3_d;
      row_pn_q <= row_pn_d;
      col_pn_q <= col_pn_d;
      past_q   <= past_d;
      busy_q   <= busy_d;
      done_n_q <= done_n_d;
    end
  end

  assign row_pn     = row_pn_q;
  assign col_pn     = col_pn_q;
  assign past_state = past_q;
  assign busy       = busy_q;
  assign done_n     = done_n_q;

endmodule

// File: tb/tb_actuator_column_sequencer.sv
// -----------------------------------------------------------------------------
// tb_actuator_column_sequencer
//
// Self-checking bench. A table of directed sequences and a batch of random
// sequences are each compared cycle by cycle against an expected pad trace
// built from the sequencing rules (list of phases with their lengths), plus
// the done cycle and the resulting past_state. Hand-written sequences cover
// enable abort, start/ccr changes while busy and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_actuator_column_sequencer;

  localparam logic [9:0] HIZ_R = 10'h2AA;
  localparam logic [3:0] HIZ_C = 4'hA;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        start;
  logic [9:0]  target_state;
  logic        use_past;
  logic        invert;
  logic [31:0] ccr0, ccr1, ccr2, ccr3;
  logic [9:0]  row_pn;
  logic [3:0]  col_pn;
  logic [9:0]  past_state;
  logic        busy;
  logic        done_n;

  actuator_column_sequencer #(
    .NUM_COLS(2),
    .NUM_ROWS(5),
    .TIMER_W (32)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .start       (start),
    .target_state(target_state),
    .use_past    (use_past),
    .invert      (invert),
    .ccr0        (ccr0),
    .ccr1        (ccr1),
    .ccr2        (ccr2),
    .ccr3        (ccr3),
    .row_pn      (row_pn),
    .col_pn      (col_pn),
    .past_state  (past_state),
    .busy        (busy),
    .done_n      (done_n)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0] row;
    logic [3:0] col;
    logic       busy;
    logic       done_n;
  } exp_t;

  typedef struct {
    logic [9:0]  tgt;
    logic        up;
    logic        inv;
    logic [31:0] c0, c1, c2, c3;
    int          done;   // expected done cycle, -1: take it from the model
    logic [9:0]  past;   // expected past_state (used when done >= 0)
  } vec_t;

  int         n_cmp  = 0;
  int         n_fail = 0;
  exp_t       exp_q[$];
  logic [9:0] model_past;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int plen(input logic [31:0] v);
    return (v == 32'd0) ? 1 : int'(v);
  endfunction

  task automatic push_n(input int n, input exp_t e);
    repeat (n) exp_q.push_back(e);
  endtask

  // Expected pad trace: one entry per cycle starting with cycle 1 after the
  // accepting edge, ending with the done cycle and one idle cycle.
  task automatic build_trace(input vec_t v, output logic [9:0] t);
    logic [9:0] sm, cm;
    logic [4:0] s, k;
    exp_t       e, quiet;
    bit         first;
    exp_q.delete();
    t  = v.inv ? ~v.tgt : v.tgt;
    sm = v.up ? (t & ~model_past) : t;
    cm = v.up ? (~t & model_past) : ~t;
    quiet = '{row: HIZ_R, col: HIZ_C, busy: 1'b1, done_n: 1'b1};
    first = 1'b1;
    for (int c = 0; c < 2; c++) begin
      s = sm[c*5 +: 5];
      k = cm[c*5 +: 5];
      if (s == 5'd0 && k == 5'd0) continue;
      if (!first) push_n(plen(v.c3), quiet);
      first = 1'b0;
      if (s != 5'd0) begin
        e = quiet;
        for (int r = 0; r < 5; r++) if (s[r]) e.row[2*r +: 2] = 2'b11;
        e.col[2*c +: 2] = 2'b00;
        push_n(plen(v.c1), e);
        push_n(plen(v.c0), quiet);
      end
      if (k != 5'd0) begin
        e = quiet;
        for (int r = 0; r < 5; r++) if (k[r]) e.row[2*r +: 2] = 2'b00;
        e.col[2*c +: 2] = 2'b11;
        push_n(plen(v.c2), e);
        push_n(plen(v.c0), quiet);
      end
    end
    exp_q.push_back('{row: HIZ_R, col: HIZ_C, busy: 1'b0, done_n: 1'b0});
    exp_q.push_back('{row: HIZ_R, col: HIZ_C, busy: 1'b0, done_n: 1'b1});
  endtask

  function automatic bit pins_ok(input logic [9:0] r_pn, input logic [3:0] c_pn);
    bit ok;
    ok = 1'b1;
    for (int r = 0; r < 5; r++) if (r_pn[2*r +: 2] == 2'b01) ok = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c_pn[2*c +: 2] == 2'b01) ok = 1'b0;
      for (int r = 0; r < 5; r++) begin
        if ((c_pn[2*c +: 2] == 2'b00 || c_pn[2*c +: 2] == 2'b11) &&
            c_pn[2*c +: 2] == r_pn[2*r +: 2]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  task automatic run_seq(input string name, input vec_t v, input bit poke);
    logic [9:0] t;
    exp_t       got, bad_got, bad_exp;
    bit         bad;
    int         pin_bad, done_at, exp_done;
    logic [9:0] exp_past;
    build_trace(v, t);
    exp_done = (v.done >= 0) ? v.done : exp_q.size() - 1;
    exp_past = (v.done >= 0) ? v.past : t;

    @(negedge clock);
    enable       = 1'b1;
    target_state = v.tgt;
    use_past     = v.up;
    invert       = v.inv;
    ccr0 = v.c0; ccr1 = v.c1; ccr2 = v.c2; ccr3 = v.c3;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;

    bad = 1'b0; pin_bad = 0; done_at = 0;
    bad_got = '0; bad_exp = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      start = 1'b0;
      got = {row_pn, col_pn, busy, done_n};
      if (!bad) begin
        bad_got = got;
        bad_exp = exp_q[i];
        if (got !== exp_q[i]) bad = 1'b1;
      end
      if (!pins_ok(row_pn, col_pn)) pin_bad++;
      if (done_n === 1'b0 && done_at == 0) done_at = i + 1;
      // Requests and new CCR/target values while busy must have no effect.
      if (poke && i == 3 && i + 2 < exp_q.size()) begin
        start        = 1'b1;
        target_state = ~v.tgt;
        ccr1         = 32'd9;
        ccr3         = 32'd1;
      end
    end
    check({name, " trace"},      64'(bad_got),  64'(bad_exp));
    check({name, " pins_legal"}, 64'(pin_bad),  64'(0));
    check({name, " done_cycle"}, 64'(done_at),  64'(exp_done));
    check({name, " past_state"}, 64'(past_state), 64'(exp_past));
    model_past = t;
  endtask

  vec_t tbl[7];
  vec_t v;
  int   low_cnt, busy_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{10'h3FF, 1'b0, 1'b0, 32'd4, 32'd15, 32'h80, 32'hF0, 279, 10'h3FF};
    tbl[1] = '{10'h3FE, 1'b1, 1'b0, 32'd4, 32'd15, 32'h80, 32'hF0, 133, 10'h3FE};
    tbl[2] = '{10'h3FE, 1'b1, 1'b0, 32'd4, 32'd15, 32'h80, 32'hF0, 1,   10'h3FE};
    tbl[3] = '{10'h000, 1'b0, 1'b0, 32'd2, 32'd3,  32'd5,  32'd7,  22,  10'h000};
    tbl[4] = '{10'h000, 1'b1, 1'b1, 32'd4, 32'd15, 32'h80, 32'hF0, 279, 10'h3FF};
    tbl[5] = '{10'h01F, 1'b1, 1'b0, 32'd0, 32'd0,  32'd0,  32'd0,  3,   10'h01F};
    tbl[6] = '{10'h2A5, 1'b1, 1'b0, 32'd1, 32'd2,  32'd3,  32'd2,  10,  10'h2A5};

    reset_n = 1'b0; enable = 1'b0; start = 1'b0;
    target_state = '0; use_past = 1'b0; invert = 1'b0;
    ccr0 = '0; ccr1 = '0; ccr2 = '0; ccr3 = '0;
    model_past = '0;
    #12;
    check("reset_values", 64'({row_pn, col_pn, past_state, busy, done_n}),
          64'({HIZ_R, HIZ_C, 10'h000, 1'b0, 1'b1}));
    @(negedge clock);
    reset_n = 1'b1;
    enable  = 1'b1;

    // Directed table.
    for (int i = 0; i < 7; i++) run_seq($sformatf("tbl%0d", i), tbl[i], 1'b0);

    // Enable dropped during the gap of the full 0x3FF sequence.
    @(negedge clock);
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    model_past = '0;
    check("reset_past", 64'(past_state), 64'(0));
    @(negedge clock);
    target_state = 10'h3FF; use_past = 1'b0; invert = 1'b0;
    ccr0 = 32'd4; ccr1 = 32'd15; ccr2 = 32'h80; ccr3 = 32'hF0;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (100) @(negedge clock);
    check("gap_state", 64'({row_pn, col_pn, busy, done_n}),
          64'({HIZ_R, HIZ_C, 1'b1, 1'b1}));
    enable = 1'b0;
    @(negedge clock);
    check("abort_outputs", 64'({row_pn, col_pn, busy, done_n}),
          64'({HIZ_R, HIZ_C, 1'b0, 1'b1}));
    low_cnt = 0; busy_cnt = 0;
    repeat (250) begin
      @(negedge clock);
      if (done_n === 1'b0) low_cnt++;
      if (busy !== 1'b0) busy_cnt++;
      if (row_pn !== HIZ_R || col_pn !== HIZ_C) busy_cnt++;
    end
    check("abort_no_done", 64'(low_cnt), 64'(0));
    check("abort_quiet",   64'(busy_cnt), 64'(0));
    check("abort_past",    64'(past_state), 64'(0));
    enable = 1'b1;
    run_seq("after_abort", tbl[0], 1'b0);

    // Start, target and CCR changes while busy are ignored.
    v = '{10'h155, 1'b0, 1'b0, 32'd2, 32'd5, 32'd4, 32'd3, -1, 10'h000};
    run_seq("poke", v, 1'b1);

    // Asynchronous reset in the middle of a SET phase.
    @(negedge clock);
    target_state = 10'h3FF; use_past = 1'b0; invert = 1'b0;
    ccr0 = 32'd2; ccr1 = 32'd20; ccr2 = 32'd3; ccr3 = 32'd2;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_set", 64'({row_pn, col_pn, busy}), 64'({10'h3FF, 4'b1000, 1'b1}));
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", 64'({row_pn, col_pn, past_state, busy, done_n}),
          64'({HIZ_R, HIZ_C, 10'h000, 1'b0, 1'b1}));
    @(negedge clock);
    reset_n = 1'b1;
    model_past = '0;

    // Random sequences against the trace model.
    for (int n = 0; n < 40; n++) begin
      v.tgt  = 10'($urandom);
      v.up   = 1'($urandom);
      v.inv  = 1'($urandom);
      v.c0   = $urandom_range(0, 5);
      v.c1   = $urandom_range(0, 6);
      v.c2   = $urandom_range(0, 6);
      v.c3   = $urandom_range(0, 5);
      v.done = -1;
      v.past = '0;
      run_seq($sformatf("rnd%0d", n), v, 1'(n % 5 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
